// File: rtl/waveform_source_arbiter_if.sv
// AXI-Stream bundle between the waveform-load sources and the formatter.
// The s_* side carries NUM_SRC packed source lanes; the m_* side is the single
// formatter input. The arbiter takes the slave view, the environment the master view.
interface waveform_source_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [32*NUM_SRC-1:0] s_tdata;
  logic [4*NUM_SRC-1:0]  s_tkeep;
  logic [NUM_SRC-1:0]    s_tvalid;
  logic [NUM_SRC-1:0]    s_tlast;
  logic [NUM_SRC-1:0]    s_tready;
  logic [31:0]           m_tdata;
  logic [3:0]            m_tkeep;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;

  modport slave (
    input  s_tdata, s_tkeep, s_tvalid, s_tlast,
    output s_tready,
    output m_tdata, m_tkeep, m_tvalid, m_tlast,
    input  m_tready
  );

  modport master (
    output s_tdata, s_tkeep, s_tvalid, s_tlast,
    input  s_tready,
    input  m_tdata, m_tkeep, m_tvalid, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/waveform_source_arbiter.sv
// Packet-level round-robin arbiter feeding the waveform formatter.
// A whole packet is granted at a time; packets whose first beat is not the
// WFRM_CMD header word are drained from their source and counted, never forwarded.
//
//  state  | meaning
//  IDLE   | no grant; searching for a requester while wf_write_ready is high
//  GRANT  | one bubble cycle so the grant mux settles
//  HDR    | first beat: header decides forward or drain
//  PASS   | forwarding the rest of a valid packet
//  DROP   | draining the rest of a packet with a bad header
module waveform_source_arbiter #(
  parameter int          NUM_SRC  = 2,
  parameter logic [31:0] WFRM_CMD = 32'h57574441,
  parameter int          CNT_W    = 16
) (
  input  logic                axi_tclk,
  input  logic                axi_treset,
  input  logic [NUM_SRC-1:0]  src_enable,
  input  logic                wf_write_ready,
  waveform_source_arbiter_if.slave bus,
  output logic [1:0]          grant_idx,
  output logic                busy,
  output logic [CNT_W-1:0]    pkt_count,
  output logic [CNT_W-1:0]    drop_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_HDR,
    ST_PASS,
    ST_DROP
  } state_t;

  state_t             r_state;
  logic [1:0]         r_grant;
  logic [1:0]         r_last;
  logic [CNT_W-1:0]   r_pkt_count;
  logic [CNT_W-1:0]   r_drop_count;

  logic [NUM_SRC-1:0] w_req;
  logic [1:0]         w_pick;
  int                 w_best;
  int                 w_dist;
  logic [31:0]        w_sel_tdata;
  logic [3:0]         w_sel_tkeep;
  logic               w_sel_tvalid;
  logic               w_sel_tlast;
  logic               w_active;
  logic               w_match;
  logic               w_fwd;
  logic               w_drain;
  logic [NUM_SRC-1:0] w_tready;

  assign w_req = bus.s_tvalid & src_enable;

  // Round-robin search: the requester closest after the last served source wins.
  always_comb begin
    w_pick = '0;
    w_best = NUM_SRC;
    w_dist = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_dist = (i + NUM_SRC - 1 - int'(r_last)) % NUM_SRC;
      if (w_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_pick = 2'(i);
      end
    end
  end

  // Select the granted source's stream lane.
  always_comb begin
    w_sel_tdata  = '0;
    w_sel_tkeep  = '0;
    w_sel_tvalid = 1'b0;
    w_sel_tlast  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == 2'(i)) begin
        w_sel_tdata  = bus.s_tdata[32*i +: 32];
        w_sel_tkeep  = bus.s_tkeep[4*i +: 4];
        w_sel_tvalid = bus.s_tvalid[i];
        w_sel_tlast  = bus.s_tlast[i];
      end
    end
  end

  assign w_active = (r_state == ST_HDR) || (r_state == ST_PASS) || (r_state == ST_DROP);
  assign w_match  = (w_sel_tdata == WFRM_CMD);
  // The header is re-evaluated each HDR cycle, so a source idling before its
  // first beat cannot commit the packet to the wrong path.
  assign w_fwd    = (r_state == ST_PASS) || ((r_state == ST_HDR) && w_match);
  assign w_drain  = (r_state == ST_DROP) || ((r_state == ST_HDR) && !w_match);

  assign bus.m_tvalid = w_fwd & w_sel_tvalid;
  assign bus.m_tdata  = w_active ? w_sel_tdata : 32'd0;
  assign bus.m_tkeep  = w_active ? w_sel_tkeep : 4'd0;
  assign bus.m_tlast  = w_active ? w_sel_tlast : 1'b0;

  // Only the granted source sees ready: backpressure when forwarding, always-ready when draining.
  always_comb begin
    w_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == 2'(i)) begin
        w_tready[i] = w_fwd ? bus.m_tready : w_drain;
      end
    end
  end
  assign bus.s_tready = w_tready;

  // Packet sequencer: grant, header check, forward/drain, counters and rr pointer.
  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'd0;
      r_last       <= 2'(NUM_SRC - 1);
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wf_write_ready && (|w_req)) begin
            r_grant <= w_pick;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: r_state <= ST_HDR;
        ST_HDR: begin
          if (w_match) begin
            if (w_sel_tvalid && bus.m_tready) begin
              if (w_sel_tlast) begin
                r_pkt_count <= r_pkt_count + 1'b1;
                r_last      <= r_grant;
                r_state     <= ST_IDLE;
              end else begin
                r_state <= ST_PASS;
              end
            end
          end else if (w_sel_tvalid) begin
            if (w_sel_tlast) begin
              r_drop_count <= r_drop_count + 1'b1;
              r_last       <= r_grant;
              r_state      <= ST_IDLE;
            end else begin
              r_state <= ST_DROP;
            end
          end
        end
        ST_PASS: begin
          if (w_sel_tvalid && bus.m_tready && w_sel_tlast) begin
            r_pkt_count <= r_pkt_count + 1'b1;
            r_last      <= r_grant;
            r_state     <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (w_sel_tvalid && w_sel_tlast) begin
            r_drop_count <= r_drop_count + 1'b1;
            r_last       <= r_grant;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_idx  = r_grant;
  assign busy       = (r_state != ST_IDLE);
  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;

endmodule
